// File: rtl/lcd_hd44780_responder.sv
// LCD-side HD44780 bus responder: DDRAM/CGRAM, address counter and busy flag.
// Define LCD_RESP_READ_EN to enable status and data reads on the bus.
module lcd_hd44780_responder #(
    parameter int EXEC_CYCLES    = 2000,
    parameter int CLEAR_CYCLES   = 82080,
    parameter int POWERON_CYCLES = 810000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic       lcd_en,
    input  logic [7:0] lcd_data_in,
    output logic [7:0] lcd_data_out,
    output logic       lcd_data_oe,
    output logic       busy,
    output logic [2:0] disp_ctrl,
    output logic [2:0] func_set,
    output logic       entry_id,
    output logic [6:0] addr_cnt,
    output logic       busy_err,
    input  logic [6:0] dbg_addr,
    output logic [7:0] dbg_data
);

    localparam int BOOT_CYCLES = (POWERON_CYCLES > 80) ? POWERON_CYCLES : 80;
    localparam int MAX_A = (BOOT_CYCLES > CLEAR_CYCLES) ? BOOT_CYCLES : CLEAR_CYCLES;
    localparam int MAX_C = (MAX_A > EXEC_CYCLES) ? MAX_A : EXEC_CYCLES;
    localparam int CW = $clog2(MAX_C + 1);

`ifdef LCD_RESP_READ_EN
    localparam logic RD_EN = 1'b1;
`else
    localparam logic RD_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        CLEAR
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [6:0]    fill_idx, fill_n;
    logic [6:0]    ac_n;
    logic          target, target_n;
    logic [2:0]    disp_n, func_n;
    logic          entry_n, err_n;
    logic          en_q;
    logic          cap_rs, cap_rw;
    logic [7:0]    cap_d;

    logic [7:0] ddram [80];
    logic [7:0] cgram [64];

    logic       dd_we, cg_we;
    logic [6:0] dd_wa;
    logic [7:0] dd_wd;

    logic fall, access, go;
    logic is_cmd, is_wr, is_srd, is_drd;
    logic c_dd, c_cg, c_fn, c_sh, c_dc, c_em, c_hm, c_cl;

    // DDRAM lines 0x00-0x27 and 0x40-0x67 pack into 80 contiguous bytes
    function automatic logic dd_valid(input logic [6:0] a);
        return a[5:0] < 6'd40;
    endfunction

    function automatic logic [6:0] dd_index(input logic [6:0] a);
        return a[6] ? {1'b0, a[5:0]} + 7'd40 : {1'b0, a[5:0]};
    endfunction

    function automatic logic [6:0] ac_step(
        input logic [6:0] a,
        input logic       inc,
        input logic       cg
    );
        logic [6:0] r;
        if (cg)
            r = {1'b0, inc ? a[5:0] + 6'd1 : a[5:0] - 6'd1};
        else if (inc)
            r = (a == 7'h27) ? 7'h40 : (a == 7'h67) ? 7'h00 : a + 7'd1;
        else
            r = (a == 7'h00) ? 7'h67 : (a == 7'h40) ? 7'h27 : a - 7'd1;
        return r;
    endfunction

    assign busy   = (state != IDLE);
    assign fall   = en_q & ~lcd_en;
    assign is_cmd = ~cap_rs & ~cap_rw;
    assign is_wr  = cap_rs & ~cap_rw;
    assign is_srd = ~cap_rs & cap_rw;
    assign is_drd = cap_rs & cap_rw;
    assign access = fall & (~cap_rw | RD_EN);
    assign go     = access & ~busy;

    // One-hot leading-one classes of the instruction byte
    assign c_dd = cap_d[7];
    assign c_cg = (cap_d[7:6] == 2'b01);
    assign c_fn = (cap_d[7:5] == 3'b001);
    assign c_sh = (cap_d[7:4] == 4'b0001);
    assign c_dc = (cap_d[7:3] == 5'b00001);
    assign c_em = (cap_d[7:2] == 6'b000001);
    assign c_hm = (cap_d[7:1] == 7'b0000001);
    assign c_cl = (cap_d == 8'h01);

    always_ff @(posedge clk) begin
        if (lcd_en) begin
            cap_rs <= lcd_rs;
            cap_rw <= lcd_rw;
            cap_d  <= lcd_data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= CLEAR;
            cnt       <= CW'(BOOT_CYCLES);
            fill_idx  <= 7'd0;
            en_q      <= 1'b0;
            addr_cnt  <= 7'd0;
            target    <= 1'b0;
            disp_ctrl <= 3'b000;
            func_set  <= 3'b100;
            entry_id  <= 1'b1;
            busy_err  <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            fill_idx  <= fill_n;
            en_q      <= lcd_en;
            addr_cnt  <= ac_n;
            target    <= target_n;
            disp_ctrl <= disp_n;
            func_set  <= func_n;
            entry_id  <= entry_n;
            busy_err  <= err_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        fill_n   = fill_idx;
        ac_n     = addr_cnt;
        target_n = target;
        disp_n   = disp_ctrl;
        func_n   = func_set;
        entry_n  = entry_id;
        err_n    = 1'b0;
        dd_we    = 1'b0;
        dd_wa    = fill_idx;
        dd_wd    = 8'h20;
        cg_we    = 1'b0;

        if (state != IDLE) begin
            if (cnt <= CW'(1))
                state_n = IDLE;
            else
                cnt_n = cnt - CW'(1);
        end

        if (state == CLEAR && fill_idx < 7'd80) begin
            dd_we  = 1'b1;
            fill_n = fill_idx + 7'd1;
        end

        // Status reads stay legal while busy; anything else is refused
        if (access && busy)
            err_n = ~is_srd;

        if (go && is_cmd) begin
            if (cap_d != 8'h00) begin
                state_n = EXEC;
                cnt_n   = CW'(EXEC_CYCLES);
            end
            unique case (1'b1)
                c_dd: begin
                    ac_n     = cap_d[6:0];
                    target_n = 1'b0;
                end
                c_cg: begin
                    ac_n     = {1'b0, cap_d[5:0]};
                    target_n = 1'b1;
                end
                c_fn: func_n = cap_d[4:2];
                c_sh: begin
                    if (!cap_d[3])
                        ac_n = ac_step(addr_cnt, cap_d[2], target);
                end
                c_dc: disp_n = cap_d[2:0];
                c_em: entry_n = cap_d[1];
                c_hm: begin
                    ac_n  = 7'd0;
                    cnt_n = CW'(CLEAR_CYCLES);
                end
                c_cl: begin
                    ac_n     = 7'd0;
                    entry_n  = 1'b1;
                    target_n = 1'b0;
                    fill_n   = 7'd0;
                    state_n  = CLEAR;
                    cnt_n    = CW'(CLEAR_CYCLES);
                end
                default: ;
            endcase
        end

        if (go && (is_wr || is_drd)) begin
            state_n = EXEC;
            cnt_n   = CW'(EXEC_CYCLES);
            ac_n    = ac_step(addr_cnt, entry_id, target);
            if (is_wr && target) begin
                cg_we = 1'b1;
            end else if (is_wr && dd_valid(addr_cnt)) begin
                dd_we = 1'b1;
                dd_wa = dd_index(addr_cnt);
                dd_wd = cap_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (dd_we && !reset)
            ddram[dd_wa] <= dd_wd;
        if (cg_we && !reset)
            cgram[addr_cnt[5:0]] <= cap_d;
        if (reset)
            dbg_data <= 8'h00;
        else if (dd_valid(dbg_addr))
            dbg_data <= ddram[dd_index(dbg_addr)];
        else
            dbg_data <= 8'h00;
    end

`ifdef LCD_RESP_READ_EN
    logic [7:0] rd_byte;

    always_comb begin
        rd_byte = 8'h00;
        if (target)
            rd_byte = cgram[addr_cnt[5:0]];
        else if (dd_valid(addr_cnt))
            rd_byte = ddram[dd_index(addr_cnt)];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lcd_data_oe  <= 1'b0;
            lcd_data_out <= 8'h00;
        end else begin
            lcd_data_oe  <= lcd_en & lcd_rw;
            if (lcd_en && lcd_rw)
                lcd_data_out <= lcd_rs ? rd_byte : {busy, addr_cnt};
            else
                lcd_data_out <= 8'h00;
        end
    end
`else
    assign lcd_data_oe  = 1'b0;
    assign lcd_data_out = 8'h00;
`endif

endmodule
